arb4_rr: RTL
============

Name: arb4_rr

Overview:
- Four-requester round-robin arbiter with grant hold and a hold-timeout, for sharing one resource among four clients.
- Extends the two-way arb2 scheme to N ports.
- Adds fairness: rotating priority and a bounded tenure per grant.
- Sits between requesting masters and the shared resource; grants are registered, one-hot.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 8, maximum consecutive cycles a grant is held while others are waiting (1..255).
- CW, 8, hold-counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; 0 = in reset.
- req  input  N  request vector; bit i high = requester i wants the resource, held until done.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_id  output  3  index of the current owner; valid only when busy=1, 0 otherwise.
- busy  output  1  high whenever any gnt bit is high.

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt=0, gnt_id=0, busy=0, hold count=0, state=IDLE.
  - Last-owner pointer = N-1, so requester 0 has top priority after reset.
  - Release is synchronous to clk; a request pending at the first active edge is serviced at that edge.
- Arbitration:
  - Search order starts at (last_owner+1) mod N and wraps to last_owner.
  - The first set req bit in that order wins.
- Latency: req sampled at edge t produces gnt at edge t (registered); it is visible during cycle t..t+1, i.e. one cycle after req is asserted.
- FSM states: IDLE, OWN.
- IDLE:
  - req==0: stay, gnt=0.
  - Any req: grant the winner, load last_owner=winner, count=1, go to OWN.
- OWN, owner o:
  - req[o]=1, count<MAX_HOLD: keep gnt, count++.
  - req[o]=0 (release):
    - If other req pending, hand over at the same edge (no idle bubble) to the next winner after o; count=1.
    - Otherwise gnt=0, go to IDLE.
  - req[o]=1, count==MAX_HOLD (timeout):
    - If any other req bit is set, force rotation to the next winner after o; count=1.
    - If o is the only requester, keep o and reset count=1.
- Count saturates logic-wise at MAX_HOLD; it never wraps.
- Simultaneous events:
  - Release and new requests at the same edge: handover.
  - Release and timeout together: treated as release.
- Requests by non-owners during OWN are only honoured at release or timeout; there is no preemption.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[i] is never asserted unless req[i] was high at the granting edge.
  - busy == |gnt.
  - gnt_id matches the set bit of gnt.
- Reset mid-grant: outputs clear immediately (asynchronously); the pointer returns to N-1.

Decomposition:
- Package arb_pkg:
  - State enum (IDLE, OWN).
  - Function next_winner(req, last) returning index and valid.
  - Localparam for gnt_id width (3 bits).
- One sub-module, rr_pick:
  - Combinational rotate-priority encoder.
  - Inputs: req[N-1:0], last[2:0].
  - Outputs: idx[2:0], valid.
  - Reused by later arbiters.

Test Plan:
- Reset then req=4'b1111 held: grants in order 0,1,2,3,0,… Each tenure lasts exactly 8 cycles; handover occurs with no bubble and busy stays 1.
- Single requester: req=4'b0100 for 20 cycles:
  - gnt=4'b0100 continuously.
  - count reloads at cycles 8 and 16.
  - gnt drops one cycle after req[2] falls; busy=0.
- Release handover: gnt=4'b0001 active, req changes from 0001 to 1010 at the same edge. Next gnt=4'b0010, gnt_id=1, with no idle cycle in between.
- Wrap priority: last owner=3, req=4'b1001. The next grant goes to 0, not 3. Afterwards, with req=4'b1001 still held, 3 is granted after 0 releases or times out.
- Async reset mid-grant: gnt=4'b0100, then rst pulled to 0 between clock edges. gnt, busy and gnt_id clear immediately without a clock edge. After release with req=4'b1111, the grant goes to 0.
- Random req at every cycle for 1000 cycles, checked by assertions:
  - One-hot gnt.
  - No grant without a request.
  - No tenure longer than MAX_HOLD while another request is pending.
  - Each waiting requester is granted within (N-1)*MAX_HOLD+1 cycles.

Source files
------------

// File: rtl/arb4_rr_pkg.sv
// Shared types and the rotate-priority search used by the round-robin arbiters.
// The search is written for up to MAXN requesters so narrower arbiters can reuse it.
package arb_pkg;
  localparam int IDW  = 3;
  localparam int MAXN = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] idx;
  } pick_t;

  // First set bit scanning from (last+1) mod n, wrapping round to last itself.
  function automatic pick_t next_winner(input logic [MAXN-1:0] req,
                                        input logic [IDW-1:0]  last,
                                        input int              n);
    pick_t          p;
    int             i;
    logic [IDW-1:0] ii;
    p = '0;
    for (int k = 1; k <= MAXN; k++) begin
      if (k <= n) begin
        i  = (int'(last) + k) % n;
        ii = i[IDW-1:0];
        if (!p.valid && req[ii]) begin
          p.valid = 1'b1;
          p.idx   = ii;
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/arb4_rr_pick.sv
// Combinational rotate-priority encoder: picks the first requester after last, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  logic [MAXN-1:0] req_w;
  pick_t           p;

  always_comb begin
    req_w        = '0;
    req_w[N-1:0] = req;
    p            = next_winner(req_w, last, N);
    idx          = p.idx;
    valid        = p.valid;
  end

endmodule

// File: rtl/arb4_rr.sv
// N-way round-robin arbiter with registered one-hot grant and a bounded tenure.
// The last-owner register doubles as the current owner while in OWN.
module arb4_rr
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy
);

  state_t         state, state_n;
  logic [IDW-1:0] last, last_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [IDW-1:0] pick_idx;
  logic           pick_vld;
  logic           own_req;

  // Searching from last covers every case: after a release the owner's bit is
  // clear, and on timeout the owner is only found again if nobody else waits.
  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign own_req = |(req & (N'(1) << last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= IDW'(N - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    if (state == OWN && own_req && cnt < CW'(MAX_HOLD)) begin
      cnt_n = cnt + CW'(1);
    end else if (pick_vld) begin
      state_n = OWN;
      last_n  = pick_idx;
      cnt_n   = CW'(1);
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    busy   = 1'b0;
    if (state == OWN) begin
      gnt    = N'(1) << last;
      gnt_id = last;
      busy   = 1'b1;
    end
  end

endmodule
